// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants and the destination-tag type carried down the shadow pipeline.
// Forward-select encodings are fixed because the EX-stage operand muxes decode them.
package hazard_forward_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_W      = 2;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] write_reg;
    } tag_t;

    localparam tag_t BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the decode stage and the hazard/forward controller, plus tag debug taps.
// No handshake: every input is sampled at posedge clk and every output is valid for the whole cycle.
interface hazard_forward_ctrl_if;
    import hazard_forward_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UseRt;
    logic [REG_ADDR_W-1:0] ID_WriteReg;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  flush;
    logic                  mem_stall;

    logic [FWD_W-1:0]      ForwardA;
    logic [FWD_W-1:0]      ForwardB;
    logic                  load_use_stall;
    logic                  PC_write;
    logic                  IFID_write;

    tag_t                  ex_tag;
    tag_t                  mem_tag;
    tag_t                  wb_tag;

    modport master (
        output ID_Rs, ID_Rt, ID_UseRt, ID_WriteReg, ID_RegWrite, ID_MemRead, flush, mem_stall,
        input  ForwardA, ForwardB, load_use_stall, PC_write, IFID_write, ex_tag, mem_tag, wb_tag
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UseRt, ID_WriteReg, ID_RegWrite, ID_MemRead, flush, mem_stall,
        output ForwardA, ForwardB, load_use_stall, PC_write, IFID_write, ex_tag, mem_tag, wb_tag
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_compare.sv
// Picks the forward source for one operand from the producers now in EX and MEM.
// Looked at one cycle early: the EX producer will sit in MEM, the MEM producer in WB.
module hazard_forward_ctrl_fwd_compare
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src,
    input  tag_t                  ex_tag,
    input  tag_t                  mem_tag,
    output logic [FWD_W-1:0]      sel
);

    always_comb begin
        sel = FWD_REG;
        // $0 is hardwired; the newer producer takes priority.
        if (src != '0) begin
            if (ex_tag.reg_write && ex_tag.write_reg == src) begin
                sel = FWD_MEM;
            end else if (mem_tag.reg_write && mem_tag.write_reg == src) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Shadow EX/MEM/WB tag pipeline, registered forward selects and load-use stall control.
// Selects are registered on the ID->EX edge so they stay stable for the whole EX cycle.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    tag_t                  ex_tag;
    tag_t                  mem_tag;
    tag_t                  wb_tag;
    tag_t                  id_tag;
    logic [FWD_W-1:0]      fwd_a;
    logic [FWD_W-1:0]      fwd_b;
    logic [FWD_W-1:0]      sel_a;
    logic [FWD_W-1:0]      sel_b;
    logic [REG_ADDR_W-1:0] src_b;
    logic                  hazard;
    logic                  stall;
    logic                  bubble;

    assign id_tag = '{reg_write: bus.ID_RegWrite, mem_read: bus.ID_MemRead,
                      write_reg: bus.ID_WriteReg};
    assign src_b  = bus.ID_UseRt ? bus.ID_Rt : '0;

    hazard_forward_ctrl_fwd_compare u_cmp_a (
        .src     (bus.ID_Rs),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .sel     (sel_a)
    );

    hazard_forward_ctrl_fwd_compare u_cmp_b (
        .src     (src_b),
        .ex_tag  (ex_tag),
        .mem_tag (mem_tag),
        .sel     (sel_b)
    );

    assign hazard = ex_tag.mem_read && (ex_tag.write_reg != '0) &&
                    ((ex_tag.write_reg == bus.ID_Rs) ||
                     (bus.ID_UseRt && ex_tag.write_reg == bus.ID_Rt));
    // A flushed consumer needs no stall, and a cache freeze already holds everything.
    assign stall  = hazard && !bus.flush && !bus.mem_stall;
    assign bubble = bus.flush || stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag  <= BUBBLE;
            mem_tag <= BUBBLE;
            wb_tag  <= BUBBLE;
            fwd_a   <= FWD_REG;
            fwd_b   <= FWD_REG;
        end else if (!bus.mem_stall) begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag;
            ex_tag  <= bubble ? BUBBLE : id_tag;
            fwd_a   <= bubble ? FWD_REG : sel_a;
            fwd_b   <= bubble ? FWD_REG : sel_b;
        end
    end

    assign bus.ForwardA       = fwd_a;
    assign bus.ForwardB       = fwd_b;
    assign bus.load_use_stall = stall;
    assign bus.PC_write       = !(stall || bus.mem_stall);
    assign bus.IFID_write     = !(stall || bus.mem_stall);
    assign bus.ex_tag         = ex_tag;
    assign bus.mem_tag        = mem_tag;
    assign bus.wb_tag         = wb_tag;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: instruction-level pipeline model, per-cycle compare, directed and random stimulus.
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if bus_if ();

    hazard_forward_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Model: pipe[0] is the instruction in EX, pipe[1] in MEM, pipe[2] in WB.
    typedef struct packed {
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } minst_t;

    minst_t     pipe [3];
    logic [1:0] exp_fa = 2'b00;
    logic [1:0] exp_fb = 2'b00;

    function automatic logic [1:0] fwd_model(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].wr && pipe[k].dst == src) return (k == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic stall_model();
        logic hit;
        hit = pipe[0].ld && pipe[0].dst != 5'd0 &&
              (pipe[0].dst == bus_if.ID_Rs || (bus_if.ID_UseRt && pipe[0].dst == bus_if.ID_Rt));
        return hit && !bus_if.flush && !bus_if.mem_stall;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = '0;
            exp_fa  = 2'b00;
            exp_fb  = 2'b00;
            started = 1'b1;
        end else if (!bus_if.mem_stall) begin
            logic       bub;
            logic [1:0] na;
            logic [1:0] nb;
            minst_t     ni;
            bub = bus_if.flush || stall_model();
            na  = bub ? 2'b00 : fwd_model(bus_if.ID_Rs);
            nb  = (bub || !bus_if.ID_UseRt) ? 2'b00 : fwd_model(bus_if.ID_Rt);
            ni.wr  = bus_if.ID_RegWrite;
            ni.ld  = bus_if.ID_MemRead;
            ni.dst = bus_if.ID_WriteReg;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = bub ? minst_t'(0) : ni;
            exp_fa  = na;
            exp_fb  = nb;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            logic st;
            st = stall_model();
            chk("ForwardA", 32'(bus_if.ForwardA), 32'(exp_fa));
            chk("ForwardB", 32'(bus_if.ForwardB), 32'(exp_fb));
            chk("load_use_stall", 32'(bus_if.load_use_stall), 32'(st));
            chk("PC_write", 32'(bus_if.PC_write), 32'(!(st || bus_if.mem_stall)));
            chk("IFID_write", 32'(bus_if.IFID_write), 32'(!(st || bus_if.mem_stall)));
            chk("ex_tag", 32'(bus_if.ex_tag), 32'(pipe[0]));
            chk("mem_tag", 32'(bus_if.mem_tag), 32'(pipe[1]));
            chk("wb_tag", 32'(bus_if.wb_tag), 32'(pipe[2]));
        end
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit use_rt,
                         input logic [4:0] wreg, input bit rw, input bit mr,
                         input bit fl, input bit ms);
        @(posedge clk);
        #1;
        bus_if.ID_Rs       = rs;
        bus_if.ID_Rt       = rt;
        bus_if.ID_UseRt    = use_rt;
        bus_if.ID_WriteReg = wreg;
        bus_if.ID_RegWrite = rw;
        bus_if.ID_MemRead  = mr;
        bus_if.flush       = fl;
        bus_if.mem_stall   = ms;
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus_if.ID_Rs = '0; bus_if.ID_Rt = '0; bus_if.ID_UseRt = 1'b0;
        bus_if.ID_WriteReg = '0; bus_if.ID_RegWrite = 1'b0; bus_if.ID_MemRead = 1'b0;
        bus_if.flush = 1'b0; bus_if.mem_stall = 1'b0;

        rst = 1'b1;
        nops(2);
        rst = 1'b0;
        chk("rst_fa", 32'(bus_if.ForwardA), 32'h0);
        chk("rst_fb", 32'(bus_if.ForwardB), 32'h0);
        chk("rst_stall", 32'(bus_if.load_use_stall), 32'h0);
        chk("rst_pcw", 32'(bus_if.PC_write), 32'h1);

        // add $3 then sub $3 as Rs
        drive(1, 2, 1, 3, 1, 0, 0, 0);
        drive(3, 4, 1, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_fa", 32'(bus_if.ForwardA), 32'h2);
        chk("t1_fb", 32'(bus_if.ForwardB), 32'h0);
        nops(3);

        // add $3; nop; or reading $3 as Rt, with and without ID_UseRt
        drive(1, 2, 1, 3, 1, 0, 0, 0);
        nops(1);
        drive(0, 3, 1, 6, 1, 0, 0, 0);
        nops(1);
        chk("t2_fb_use", 32'(bus_if.ForwardB), 32'h1);
        drive(1, 2, 1, 3, 1, 0, 0, 0);
        nops(1);
        drive(0, 3, 0, 6, 1, 0, 0, 0);
        nops(1);
        chk("t2_fb_nouse", 32'(bus_if.ForwardB), 32'h0);
        nops(3);

        // lw $4 then add $4: one stall, bubble, then WB forward
        drive(0, 0, 0, 4, 1, 1, 0, 0);
        drive(4, 0, 0, 11, 1, 0, 0, 0);
        chk("t3_stall", 32'(bus_if.load_use_stall), 32'h1);
        chk("t3_pcw", 32'(bus_if.PC_write), 32'h0);
        chk("t3_ifidw", 32'(bus_if.IFID_write), 32'h0);
        drive(4, 0, 0, 11, 1, 0, 0, 0);
        chk("t3_bubble_fa", 32'(bus_if.ForwardA), 32'h0);
        chk("t3_bubble_tag", 32'(bus_if.ex_tag), 32'h0);
        chk("t3_stall_off", 32'(bus_if.load_use_stall), 32'h0);
        nops(1);
        chk("t3_fa_wb", 32'(bus_if.ForwardA), 32'h1);
        nops(3);

        // $0 is never forwarded; $5 in EX and MEM forwards from the newer one
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 12, 1, 0, 0, 0);
        nops(1);
        chk("t4_zero_fa", 32'(bus_if.ForwardA), 32'h0);
        chk("t4_zero_fb", 32'(bus_if.ForwardB), 32'h0);
        drive(0, 0, 0, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 5, 1, 0, 0, 0);
        drive(5, 5, 1, 12, 1, 0, 0, 0);
        nops(1);
        chk("t4_both_fa", 32'(bus_if.ForwardA), 32'h2);
        chk("t4_both_fb", 32'(bus_if.ForwardB), 32'h2);
        nops(3);

        // cache freeze while a dependent add sits in EX
        drive(0, 0, 0, 6, 1, 0, 0, 0);
        drive(6, 0, 0, 7, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            chk("t5_hold_fa", 32'(bus_if.ForwardA), 32'h2);
            chk("t5_hold_ex", 32'(bus_if.ex_tag.write_reg), 32'h7);
            chk("t5_pcw", 32'(bus_if.PC_write), 32'h0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rel_pcw", 32'(bus_if.PC_write), 32'h1);
        nops(1);
        chk("t5_adv_mem", 32'(bus_if.mem_tag.write_reg), 32'h7);
        chk("t5_adv_fa", 32'(bus_if.ForwardA), 32'h0);
        nops(3);

        // reset in the middle of a miss with lw in EX
        drive(0, 0, 0, 9, 1, 0, 0, 0);
        drive(9, 0, 0, 8, 1, 1, 0, 0);
        drive(8, 0, 0, 13, 1, 0, 0, 1);
        chk("t6_pre_fa", 32'(bus_if.ForwardA), 32'h2);
        chk("t6_pre_stall", 32'(bus_if.load_use_stall), 32'h0);
        rst = 1'b1;
        drive(8, 0, 0, 13, 1, 0, 0, 1);
        rst = 1'b0;
        chk("t6_rst_fa", 32'(bus_if.ForwardA), 32'h0);
        chk("t6_rst_fb", 32'(bus_if.ForwardB), 32'h0);
        chk("t6_rst_ex", 32'(bus_if.ex_tag), 32'h0);
        drive(8, 0, 0, 13, 1, 0, 0, 0);
        chk("t6_rst_stall", 32'(bus_if.load_use_stall), 32'h0);
        nops(3);

        // flush and load-use in the same cycle
        drive(0, 0, 0, 10, 1, 1, 0, 0);
        drive(10, 0, 0, 14, 1, 0, 1, 0);
        chk("t6_fl_stall", 32'(bus_if.load_use_stall), 32'h0);
        chk("t6_fl_pcw", 32'(bus_if.PC_write), 32'h1);
        nops(1);
        chk("t6_fl_ex", 32'(bus_if.ex_tag), 32'h0);
        chk("t6_fl_fa", 32'(bus_if.ForwardA), 32'h0);

        // random traffic over a small register range to provoke hits
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 6) == 0));
        end
        rst = 1'b0;
        nops(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
